serial_equality_checker: RTL and testbench

- Bit-serial counterpart of the team's parallel equality comparators.
- Two operand words arrive one bit pair per accepted beat, LSB first, under a valid/ready/last handshake. The block accumulates the equality verdict, bit length and mismatch count, then presents a registered result for one pulse.
- Sits between a serialiser (switch/UART front end) and the Basys3 display/LED logic.

---
 rtl/serial_equality_checker.sv | 161 ++++++++++++++++
 tb/tb_serial_equality_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_equality_checker.sv
// Bit-serial equality checker: LSB-first bit pairs under valid/ready/last, one-cycle result pulse.
// Optional FIRST_DIFF_EN macro adds the first_diff port (index of first differing bit).
module serial_equality_checker #(
    parameter int WORD_BITS = 8,
    localparam int CNT_W = $clog2(WORD_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_last,
    output logic             result_valid,
    output logic             result_eq,
    output logic [CNT_W-1:0] result_len,
    output logic [CNT_W-1:0] result_mism,
    output logic             len_err
`ifdef FIRST_DIFF_EN
    ,
    output logic [CNT_W-1:0] first_diff
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WORD_BITS);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] mism, mism_n;
    logic             eq_acc, eq_n;
    logic             err, err_n;
    logic             beat;
    logic             diff;
`ifdef FIRST_DIFF_EN
    logic [CNT_W-1:0] fd, fd_n;
    logic             fd_seen, fd_seen_n;
`endif

    assign in_ready = ~reset & (state != S_DONE);
    assign beat     = in_valid & in_ready;
    assign diff     = in_a ^ in_b;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mism_n  = mism;
        eq_n    = eq_acc;
        err_n   = err;
`ifdef FIRST_DIFF_EN
        fd_n      = fd;
        fd_seen_n = fd_seen;
`endif
        case (state)
            S_IDLE: begin
                if (beat) begin
                    cnt_n  = CNT_W'(1);
                    eq_n   = ~diff;
                    mism_n = CNT_W'(diff);
                    err_n  = 1'b0;
`ifdef FIRST_DIFF_EN
                    fd_n      = '0;
                    fd_seen_n = diff;
`endif
                    state_n = in_last ? S_DONE : S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (beat) begin
                    cnt_n = cnt + 1'b1;
                    eq_n  = eq_acc & ~diff;
                    if (diff && (mism != MAX_CNT))
                        mism_n = mism + 1'b1;
`ifdef FIRST_DIFF_EN
                    // cnt before increment is the 0-based index of this beat
                    if (diff && !fd_seen) begin
                        fd_n      = cnt;
                        fd_seen_n = 1'b1;
                    end
`endif
                    if (in_last)
                        state_n = S_DONE;
                    else if (cnt_n == MAX_CNT)
                        state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (beat && in_last) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                mism_n  = '0;
                eq_n    = 1'b0;
                err_n   = 1'b0;
`ifdef FIRST_DIFF_EN
                fd_n      = '0;
                fd_seen_n = 1'b0;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mism   <= '0;
            eq_acc <= 1'b0;
            err    <= 1'b0;
`ifdef FIRST_DIFF_EN
            fd      <= '0;
            fd_seen <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mism   <= mism_n;
            eq_acc <= eq_n;
            err    <= err_n;
`ifdef FIRST_DIFF_EN
            fd      <= fd_n;
            fd_seen <= fd_seen_n;
`endif
        end
    end

    // Result registers load on the edge entering DONE so they are visible during DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            result_eq    <= 1'b0;
            result_len   <= '0;
            result_mism  <= '0;
            len_err      <= 1'b0;
`ifdef FIRST_DIFF_EN
            first_diff   <= '0;
`endif
        end else begin
            result_valid <= (state_n == S_DONE);
            if (state_n == S_DONE) begin
                result_eq   <= eq_n & ~err_n;
                result_len  <= cnt_n;
                result_mism <= mism_n;
                len_err     <= err_n;
`ifdef FIRST_DIFF_EN
                first_diff  <= fd_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_equality_checker.sv
// Directed bench for serial_equality_checker with a result scoreboard; honours FIRST_DIFF_EN.
module tb_serial_equality_checker;

    localparam int WB = 8;
    localparam int CW = $clog2(WB + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_a = 1'b0;
    logic          in_b = 1'b0;
    logic          in_last = 1'b0;
    logic          result_valid;
    logic          result_eq;
    logic [CW-1:0] result_len;
    logic [CW-1:0] result_mism;
    logic          len_err;
`ifdef FIRST_DIFF_EN
    logic [CW-1:0] first_diff;
`endif

    typedef struct {
        logic          eq;
        logic [CW-1:0] len;
        logic [CW-1:0] mism;
        logic          err;
        logic [CW-1:0] fd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    serial_equality_checker #(.WORD_BITS(WB)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .result_valid(result_valid), .result_eq(result_eq),
        .result_len(result_len), .result_mism(result_mism),
        .len_err(len_err)
`ifdef FIRST_DIFF_EN
        , .first_diff(first_diff)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int n);
        exp_t e;
        int   lim;
        int   mm;
        logic found;
        lim   = (n > WB) ? WB : n;
        mm    = 0;
        found = 1'b0;
        e.fd  = '0;
        for (int i = 0; i < lim; i++) begin
            if (a[i] != b[i]) begin
                mm++;
                if (!found) begin
                    e.fd  = CW'(i);
                    found = 1'b1;
                end
            end
        end
        e.err  = (n > WB);
        e.len  = CW'(lim);
        e.mism = CW'(mm);
        e.eq   = !found && !e.err;
        return e;
    endfunction

    // Called at a negedge; returns just after the posedge that accepts the beat
    task automatic send_beat(input logic a, input logic b, input logic last);
        logic acc;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int t = 0; t < 20; t++) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) return;
            @(negedge clk);
        end
        check("beat_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b, input int n);
        exp_q.push_back(model(a, b, n));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            send_beat(a[i], b[i], (i == n - 1));
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("ready_vs_done", in_ready, !result_valid);
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_eq", result_eq, e.eq);
                    check("result_len", result_len, e.len);
                    check("result_mism", result_mism, e.mism);
                    check("len_err", len_err, e.err);
`ifdef FIRST_DIFF_EN
                    check("first_diff", first_diff, e.fd);
`endif
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_eq", result_eq, 1'b0);
        check("rst_len", result_len, 0);
        check("rst_mism", result_mism, 0);
        check("rst_err", len_err, 1'b0);
`ifdef FIRST_DIFF_EN
        check("rst_fd", first_diff, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1'b1);

        send_word(16'h000B, 16'h000B, 4);
        idle(2);
        send_word(16'h00A5, 16'h00A4, 8);
        idle(2);
        send_word(16'h00F0, 16'h000F, 8);
        idle(1);
        send_word(16'h0030, 16'h0010, 8);
        idle(2);
        send_word(16'h0080, 16'h0000, 8);
        idle(2);
        send_word(16'h05A3, 16'h05A3, 11);
        idle(1);
        send_word(16'h0002, 16'h0002, 2);
        idle(2);
        // 9-bit word whose only mismatch lies in the discarded tail
        send_word(16'h01FF, 16'h00FF, 9);
        idle(2);

        // back-to-back words, in_valid held high throughout
        send_word(16'h0015, 16'h0011, 5);
        send_word(16'h0005, 16'h0005, 3);
        send_word(16'h0001, 16'h0000, 1);
        idle(3);

        // reset mid-word after beat 3 of a 6-bit word
        @(negedge clk); send_beat(1'b1, 1'b1, 1'b0);
        @(negedge clk); send_beat(1'b0, 1'b1, 1'b0);
        @(negedge clk); send_beat(1'b1, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_valid", result_valid, 1'b0);
        check("midrst_eq", result_eq, 1'b0);
        check("midrst_len", result_len, 0);
        check("midrst_mism", result_mism, 0);
        check("midrst_err", len_err, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        send_word(16'h0001, 16'h0000, 1);
        idle(2);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
